// File: rtl/alu_ctl_pkg.sv
// rtl/alu_ctl_pkg.sv - shared types and widths for the ALU sharing arbiter
package alu_ctl_pkg;

    localparam int WIDTH   = 8;
    localparam int ACODE_W = 3;
    localparam int SCODE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic               cin;
        logic               is_shift;
        logic [SCODE_W-1:0] scode;
        logic [ACODE_W-1:0] acode;
    } op_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// rtl/alu_share_arb_if.sv - requester, ALU and result signals of the ALU sharing arbiter
interface alu_share_arb_if;
    import alu_ctl_pkg::*;

    logic               req0, req1;
    logic [WIDTH-1:0]   a0, a1, b0, b1;
    logic               cin0, cin1, shift0, shift1;
    logic [SCODE_W-1:0] scode0, scode1;
    logic [ACODE_W-1:0] acode0, acode1;

    logic [WIDTH-1:0]   alu_a, alu_b;
    logic               alu_cin, alu_is_shift;
    logic [SCODE_W-1:0] alu_scode;
    logic [ACODE_W-1:0] alu_acode;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_zero, alu_cout;

    logic               busy, owner, done0, done1;
    logic [WIDTH-1:0]   r;
    logic               zero, carry_out;

    modport master (
        output req0, req1, a0, a1, b0, b1, cin0, cin1, shift0, shift1,
               scode0, scode1, acode0, acode1, alu_r, alu_zero, alu_cout,
        input  alu_a, alu_b, alu_cin, alu_is_shift, alu_scode, alu_acode,
               busy, owner, done0, done1, r, zero, carry_out
    );

    modport slave (
        input  req0, req1, a0, a1, b0, b1, cin0, cin1, shift0, shift1,
               scode0, scode1, acode0, acode1, alu_r, alu_zero, alu_cout,
        output alu_a, alu_b, alu_cin, alu_is_shift, alu_scode, alu_acode,
               busy, owner, done0, done1, r, zero, carry_out
    );

endinterface

// File: rtl/alu_arb_pick.sv
// rtl/alu_arb_pick.sv - 2-way grant picker; ALU_ARB_RR_EN selects round-robin ties, else port 0 wins
module alu_arb_pick (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_ptr,
    output logic o_grant,
    output logic o_any
);

    assign o_any = i_req0 | i_req1;

`ifdef ALU_ARB_RR_EN
    // i_ptr is the port favoured on a tie
    assign o_grant = (i_req0 & i_req1) ? i_ptr : i_req1;
`else
    logic w_unused_ptr;
    assign w_unused_ptr = i_ptr;
    assign o_grant      = i_req1 & ~i_req0;
`endif

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - shares one combinational ALU between two requesters (IDLE/EXEC/DONE)
// ALU_ARB_RR_EN defined: round-robin tie break; undefined: fixed priority to port 0.
import alu_ctl_pkg::*;

module alu_share_arb (
    input  logic           clk,
    input  logic           rst_n,
    alu_share_arb_if.slave bus
);

    state_t           r_state;
    op_t              r_alu;
    logic             r_busy, r_owner, r_done0, r_done1, r_zero, r_cout;
    logic [WIDTH-1:0] r_r;

    logic             w_grant, w_any, w_ptr;
    op_t              w_op0, w_op1, w_sel;

    assign w_op0 = '{a: bus.a0, b: bus.b0, cin: bus.cin0, is_shift: bus.shift0,
                     scode: bus.scode0, acode: bus.acode0};
    assign w_op1 = '{a: bus.a1, b: bus.b1, cin: bus.cin1, is_shift: bus.shift1,
                     scode: bus.scode1, acode: bus.acode1};
    assign w_sel = w_grant ? w_op1 : w_op0;

    alu_arb_pick u_pick (
        .i_req0  (bus.req0),
        .i_req1  (bus.req1),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

`ifdef ALU_ARB_RR_EN
    logic r_ptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= 1'b0;
        else if (r_state == ST_IDLE && w_any)
            r_ptr <= ~w_grant;
    end
    assign w_ptr = r_ptr;
`else
    assign w_ptr = 1'b0;
`endif

    // Operand registers only load on a grant so the ALU inputs stay quiet otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_alu   <= '0;
            r_busy  <= 1'b0;
            r_owner <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_r     <= '0;
            r_zero  <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_alu   <= w_sel;
                        r_owner <= w_grant;
                        r_busy  <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_r     <= bus.alu_r;
                    r_zero  <= bus.alu_zero;
                    r_cout  <= bus.alu_cout;
                    r_done0 <= ~r_owner;
                    r_done1 <= r_owner;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.alu_a        = r_alu.a;
    assign bus.alu_b        = r_alu.b;
    assign bus.alu_cin      = r_alu.cin;
    assign bus.alu_is_shift = r_alu.is_shift;
    assign bus.alu_scode    = r_alu.scode;
    assign bus.alu_acode    = r_alu.acode;
    assign bus.busy         = r_busy;
    assign bus.owner        = r_owner;
    assign bus.done0        = r_done0;
    assign bus.done1        = r_done1;
    assign bus.r            = r_r;
    assign bus.zero         = r_zero;
    assign bus.carry_out    = r_cout;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - scoreboard bench for alu_share_arb with an XOR ALU stub
module tb_alu_share_arb;
    import alu_ctl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arb_if bus ();

    alu_share_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.alu_r    = bus.alu_a ^ bus.alu_b;
    assign bus.alu_zero = (bus.alu_r == '0);
    assign bus.alu_cout = bus.alu_cin;

    typedef struct {
        bit         port;
        logic [7:0] r;
        bit         zero;
        bit         cout;
    } exp_t;

    exp_t       exp_q[$];
    int         checks     = 0;
    int         failures   = 0;
    int         cyc        = 0;
    int         done_total = 0;
    int         dcyc[$];
    logic [7:0] op_a[2];
    logic [7:0] op_b[2];
    bit         op_cin[2];
    bit         favour     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference arbitration: a lone request wins; ties go by policy
    function automatic exp_t grant(bit r0, bit r1);
        exp_t e;
        bit   w;
`ifdef ALU_ARB_RR_EN
        w      = (r0 && r1) ? favour : r1;
        favour = !w;
`else
        w      = r0 ? 1'b0 : 1'b1;
`endif
        e.port = w;
        e.r    = op_a[w] ^ op_b[w];
        e.zero = (e.r == 8'h00);
        e.cout = op_cin[w];
        return e;
    endfunction

    task automatic set_port(bit p, logic [7:0] a, logic [7:0] b, bit cin);
        op_a[p]   = a;
        op_b[p]   = b;
        op_cin[p] = cin;
        if (!p) begin
            bus.a0 = a; bus.b0 = b; bus.cin0 = cin;
            bus.shift0 = 1'($urandom); bus.scode0 = 2'($urandom); bus.acode0 = 3'($urandom);
        end else begin
            bus.a1 = a; bus.b1 = b; bus.cin1 = cin;
            bus.shift1 = 1'($urandom); bus.scode1 = 2'($urandom); bus.acode1 = 3'($urandom);
        end
    endtask

    task automatic wait_dones(int n, string name);
        int seen = 0;
        dcyc.delete();
        for (int t = 0; t < 40 * n && seen < n; t++) begin
            @(posedge clk); #1;
            if (bus.done0 || bus.done1) begin
                seen++;
                dcyc.push_back(cyc);
            end
        end
        if (seen != n) check({name, "_timeout"}, seen, n);
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_owner"}, bus.owner, 0);
        check({tag, "_done"},  {bus.done0, bus.done1}, 0);
        check({tag, "_r"},     bus.r, 0);
        check({tag, "_flags"}, {bus.zero, bus.carry_out}, 0);
        check({tag, "_alu"},   {bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_is_shift,
                                bus.alu_scode, bus.alu_acode}, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.done0 || bus.done1)) begin
            exp_t e;
            done_total++;
            check("done_onehot", bus.done0 & bus.done1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", {bus.done1, bus.done0}, 0);
            end else begin
                e = exp_q.pop_front();
                check("done_port", bus.done1, e.port);
                check("result_r", bus.r, e.r);
                check("result_zero", bus.zero, e.zero);
                check("result_cout", bus.carry_out, e.cout);
                check("owner", bus.owner, e.port);
                check("busy_at_done", bus.busy, 1);
            end
        end
    end

    initial begin
        int d0;
        int snap;
        bus.req0 = 0; bus.req1 = 0;
        set_port(0, 8'h00, 8'h00, 0);
        set_port(1, 8'h00, 8'h00, 0);

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single request on port 0
        set_port(0, 8'hE5, 8'hC7, 1);
        bus.req0 = 1;
        exp_q.push_back(grant(1, 0));
        snap = done_total;
        wait_dones(1, "single0");
        bus.req0 = 0;
        repeat (3) @(posedge clk); #1;
        check("single0_count", done_total - snap, 1);

        // zero flag on port 1
        set_port(1, 8'h5A, 8'h5A, 0);
        bus.req1 = 1;
        exp_q.push_back(grant(0, 1));
        wait_dones(1, "zero1");
        bus.req1 = 0;
        @(posedge clk); #1;

        // both held for four operations
        set_port(0, 8'($urandom), 8'($urandom), 1'($urandom));
        set_port(1, 8'($urandom), 8'($urandom), 1'($urandom));
        bus.req0 = 1; bus.req1 = 1;
        for (int i = 0; i < 4; i++) exp_q.push_back(grant(1, 1));
        wait_dones(4, "tie");
        bus.req0 = 0; bus.req1 = 0;
        for (int i = 1; i < dcyc.size(); i++) check("tie_spacing", dcyc[i] - dcyc[i-1], 3);
        @(posedge clk); #1;

        // port 1 rising during port 0's EXEC waits for the next IDLE
        set_port(0, 8'($urandom), 8'($urandom), 1'($urandom));
        bus.req0 = 1;
        exp_q.push_back(grant(1, 0));
        @(posedge clk); #1;
        set_port(1, 8'($urandom), 8'($urandom), 1'($urandom));
        bus.req1 = 1;
        exp_q.push_back(grant(0, 1));
        wait_dones(1, "late0");
        bus.req0 = 0;
        d0 = (dcyc.size() > 0) ? dcyc[0] : 0;
        wait_dones(1, "late1");
        bus.req1 = 0;
        if (dcyc.size() > 0) check("late_spacing", dcyc[0] - d0, 3);
        @(posedge clk); #1;

        // reset during EXEC drops the operation
        set_port(0, 8'h3C, 8'h0F, 1);
        bus.req0 = 1;
        @(posedge clk); #1;
        check("exec_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        bus.req0 = 0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        favour = 1'b0;
        snap   = done_total;
        repeat (5) @(posedge clk); #1;
        check("midreset_nodone", done_total - snap, 0);
        set_port(0, 8'hA5, 8'h0F, 0);
        bus.req0 = 1;
        exp_q.push_back(grant(1, 0));
        wait_dones(1, "after_reset");
        bus.req0 = 0;
        @(posedge clk); #1;

        // req0 held for nine cycles
        set_port(0, 8'($urandom), 8'($urandom), 1'($urandom));
        bus.req0 = 1;
        for (int i = 0; i < 3; i++) exp_q.push_back(grant(1, 0));
        snap = done_total;
        dcyc.delete();
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (bus.done0) dcyc.push_back(cyc);
        end
        bus.req0 = 0;
        repeat (4) @(posedge clk); #1;
        check("held_count", done_total - snap, 3);
        for (int i = 1; i < dcyc.size(); i++) check("held_spacing", dcyc[i] - dcyc[i-1], 3);

        // random singles and ties
        for (int i = 0; i < 20; i++) begin
            bit         tie;
            bit         p;
            logic [7:0] a;
            tie = 1'($urandom_range(0, 1));
            p   = 1'($urandom_range(0, 1));
            for (int q = 0; q < 2; q++) begin
                a = 8'($urandom);
                set_port(q[0], a, ($urandom_range(0, 3) == 0) ? a : 8'($urandom), 1'($urandom));
            end
            if (tie) begin
                bus.req0 = 1; bus.req1 = 1;
                exp_q.push_back(grant(1, 1));
            end else begin
                bus.req0 = !p; bus.req1 = p;
                exp_q.push_back(grant(!p, p));
            end
            wait_dones(1, "rand");
            bus.req0 = 0; bus.req1 = 0;
            if ($urandom_range(0, 1)) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) @(posedge clk); #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
